// File: rtl/conv_core_pkg.sv
// conv_core_pkg: shared types and helpers for the conv_core_array slice.
//   shadow_state_e : shadow weight bank load state (EMPTY / LOADING / FULL)
//   acc_w()        : accumulator width that holds a K*K sum of full-width
//                    signed products without overflow
package conv_core_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } shadow_state_e;

  function automatic int acc_w(input int width, input int k);
    return 2 * width + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: three-stage multiply/accumulate pipeline for one output channel.
//   S1: registers the K*K signed products (2*WIDTH bits each)
//   S2: registers their sum in acc_w(WIDTH, K) bits
//   S3: arithmetic shift right by SHIFT, saturate to signed WIDTH, register
// Optional feature macro: CONV_CORE_ARRAY_RELU_EN (clamp negative results to 0 in S3).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_vld       : a window is accepted this cycle
//   act_data     : K*K activations, element i in [i*WIDTH +: WIDTH]
//   wgt          : K*K weights for this channel, word i pairs with element i
//   psum         : saturated result, held between valid pulses
//   psum_vld     : one-cycle pulse, three cycles after in_vld
module conv_mac_lane
  import conv_core_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 3,
  parameter int SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic [K*K*WIDTH-1:0]     act_data,
  input  logic [K*K*WIDTH-1:0]     wgt,
  output logic [WIDTH-1:0]         psum,
  output logic                     psum_vld
);

  localparam int WIN = K * K;
  localparam int PW  = 2 * WIDTH;
  localparam int ACC = acc_w(WIDTH, K);

  // Saturation bounds of a signed WIDTH value, expressed in ACC bits.
  localparam logic signed [ACC-1:0] MAX_V = {{(ACC-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC-1:0] MIN_V = {{(ACC-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0]    prod_d [WIN];
  logic signed [PW-1:0]    prod_q [WIN];
  logic signed [ACC-1:0]   sum_d;
  logic signed [ACC-1:0]   sum_q;
  logic signed [ACC-1:0]   shifted;
  logic        [WIDTH-1:0] sat_d;
  logic        [WIDTH-1:0] out_d;
  logic                    v1;
  logic                    v2;

  // Operands are sign-extended to 2*WIDTH first so the product is exact.
  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      prod_d[i] = PW'($signed(act_data[i*WIDTH +: WIDTH])) *
                  PW'($signed(wgt[i*WIDTH +: WIDTH]));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < WIN; i++) begin
      sum_d = sum_d + ACC'(prod_q[i]);
    end
  end

  always_comb begin
    shifted = sum_q >>> SHIFT;
    if (shifted > MAX_V) begin
      sat_d = MAX_V[WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      sat_d = MIN_V[WIDTH-1:0];
    end else begin
      sat_d = shifted[WIDTH-1:0];
    end
`ifdef CONV_CORE_ARRAY_RELU_EN
    out_d = sat_d[WIDTH-1] ? '0 : sat_d;
`else
    out_d = sat_d;
`endif
  end

  // Datapath registers carry no reset; only the valid chain is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIN; i++) begin
      prod_q[i] <= prod_d[i];
    end
    sum_q <= sum_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      psum_vld <= 1'b0;
      psum     <= '0;
    end else begin
      v1       <= in_vld;
      v2       <= v1;
      psum_vld <= v2;
      if (v2) begin
        psum <= out_d;
      end
    end
  end

endmodule

// File: rtl/conv_core_array.sv
// conv_core_array: NUM_CH-filter convolution core over a K*K window with
// double-buffered (active / shadow) weight banks.
// Optional feature macro: CONV_CORE_ARRAY_RELU_EN (negative outputs forced to 0).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   wgt_vld/rdy   : weight word handshake; wgt_data channel c in [c*WIDTH +: WIDTH]
//   bank_swap     : shadow->active swap request, honoured only while shadow is FULL
//   wgt_full      : shadow bank holds a complete K*K set
//   act_vld/rdy   : activation window handshake; act_data element i in [i*WIDTH +: WIDTH]
//   psum/psum_vld : per-channel results, channel c in [c*WIDTH +: WIDTH]
//   shadow_state  : shadow bank FSM state, for observation
//
// Handshake: a word/window transfers on a rising edge where vld and rdy are
// both high. rdy never depends on vld. Output side has no backpressure;
// psum_vld is a single-cycle pulse and psum holds between pulses.
module conv_core_array
  import conv_core_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int K      = 3,
  parameter int NUM_CH = 4,
  parameter int SHIFT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wgt_vld,
  output logic                      wgt_rdy,
  input  logic [NUM_CH*WIDTH-1:0]   wgt_data,
  input  logic                      bank_swap,
  output logic                      wgt_full,
  input  logic                      act_vld,
  output logic                      act_rdy,
  input  logic [K*K*WIDTH-1:0]      act_data,
  output logic [NUM_CH*WIDTH-1:0]   psum,
  output logic                      psum_vld,
  output shadow_state_e             shadow_state
);

  localparam int WIN   = K * K;
  localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1;

  logic [WIDTH-1:0]  active_bank [NUM_CH][WIN];
  logic [WIDTH-1:0]  shadow_bank [NUM_CH][WIN];
  logic [IDX_W-1:0]  load_idx;
  logic              active_loaded;
  logic              wgt_fire;
  logic              swap_fire;
  logic              act_fire;
  logic [NUM_CH-1:0] lane_vld;

  assign wgt_rdy   = (shadow_state != FULL);
  assign wgt_full  = (shadow_state == FULL);
  assign act_rdy   = active_loaded;
  assign wgt_fire  = wgt_vld & wgt_rdy;
  // A swap request outside FULL is dropped, never remembered.
  assign swap_fire = bank_swap & (shadow_state == FULL);
  assign act_fire  = act_vld & act_rdy;

  // Shadow FSM and both banks. wgt_rdy is low in FULL, so a swap and a
  // weight write can never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_state  <= EMPTY;
      load_idx      <= '0;
      active_loaded <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < WIN; i++) begin
          active_bank[c][i] <= '0;
          shadow_bank[c][i] <= '0;
        end
      end
    end else if (swap_fire) begin
      active_bank   <= shadow_bank;
      active_loaded <= 1'b1;
      shadow_state  <= EMPTY;
      load_idx      <= '0;
    end else if (wgt_fire) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shadow_bank[c][load_idx] <= wgt_data[c*WIDTH +: WIDTH];
      end
      load_idx     <= load_idx + 1'b1;
      shadow_state <= (load_idx == IDX_W'(WIN - 1)) ? FULL : LOADING;
    end
  end

  // Lanes sample active_bank on the acceptance edge, so a window accepted
  // on the swap edge still multiplies by the pre-swap weights.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic [WIN*WIDTH-1:0] lane_wgt;

    always_comb begin
      lane_wgt = '0;
      for (int i = 0; i < WIN; i++) begin
        lane_wgt[i*WIDTH +: WIDTH] = active_bank[c][i];
      end
    end

    conv_mac_lane #(
      .WIDTH (WIDTH),
      .K     (K),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (act_fire),
      .act_data (act_data),
      .wgt      (lane_wgt),
      .psum     (psum[c*WIDTH +: WIDTH]),
      .psum_vld (lane_vld[c])
    );
  end

  // All lanes share one valid chain; the AND keeps every lane's flag in use.
  assign psum_vld = &lane_vld;

endmodule

// File: tb/tb_conv_core_array.sv
// tb_conv_core_array: directed bench for conv_core_array with default
// parameters (WIDTH=8, K=3, NUM_CH=4, SHIFT=0). Inputs change on the falling
// edge; outputs are compared on the falling edge. Every tick compares
// psum_vld against the expected-pulse schedule and, on a scheduled pulse,
// compares psum against the queued hand-computed value.
module tb_conv_core_array;
  import conv_core_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          wgt_vld;
  logic          wgt_rdy;
  logic [31:0]   wgt_data;
  logic          bank_swap;
  logic          wgt_full;
  logic          act_vld;
  logic          act_rdy;
  logic [71:0]   act_data;
  logic [31:0]   psum;
  logic          psum_vld;
  shadow_state_e shadow_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];
  int          due_q[$];

`ifdef CONV_CORE_ARRAY_RELU_EN
  localparam logic [31:0] NEG_SAT = 32'h0000_0000;
`else
  localparam logic [31:0] NEG_SAT = 32'h8080_8080;
`endif

  conv_core_array dut (
    .clk          (clk),
    .rst          (rst),
    .wgt_vld      (wgt_vld),
    .wgt_rdy      (wgt_rdy),
    .wgt_data     (wgt_data),
    .bank_swap    (bank_swap),
    .wgt_full     (wgt_full),
    .act_vld      (act_vld),
    .act_rdy      (act_rdy),
    .act_data     (act_data),
    .psum         (psum),
    .psum_vld     (psum_vld),
    .shadow_state (shadow_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle; scoreboard the output pulse on the falling edge.
  task automatic tick();
    logic exp_vld;
    @(negedge clk);
    cyc++;
    while (due_q.size() > 0 && due_q[0] < cyc) begin
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
    exp_vld = (due_q.size() > 0 && due_q[0] == cyc);
    check("psum_vld", {127'd0, psum_vld}, {127'd0, exp_vld});
    if (exp_vld) begin
      void'(due_q.pop_front());
      check("psum", {96'd0, psum}, {96'd0, exp_q.pop_front()});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic load_word(input logic [31:0] d);
    wgt_vld  = 1'b1;
    wgt_data = d;
    tick();
    wgt_vld  = 1'b0;
  endtask

  task automatic do_swap();
    bank_swap = 1'b1;
    tick();
    bank_swap = 1'b0;
  endtask

  // Result pulse expected on the third falling edge after the drive edge.
  task automatic send_act(input logic [71:0] a, input logic [31:0] e);
    act_vld  = 1'b1;
    act_data = a;
    exp_q.push_back(e);
    due_q.push_back(cyc + 3);
    tick();
    act_vld  = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // Channel-distinct weight word i: ch0=1, ch1=i, ch2=(i==8)?3:0, ch3=i-4.
  function automatic logic [31:0] mix_word(input int i);
    logic [7:0] c1, c2, c3;
    c1 = 8'(i);
    c2 = (i == 8) ? 8'd3 : 8'd0;
    c3 = 8'(i - 4);
    return {c3, c2, c1, 8'd1};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [71:0] ramp;

    rst       = 1'b1;
    wgt_vld   = 1'b0;
    wgt_data  = '0;
    bank_swap = 1'b0;
    act_vld   = 1'b1;
    act_data  = {9{8'd2}};
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state; act_vld held high must not be taken.
    check("rst_wgt_rdy",  {127'd0, wgt_rdy},  128'd1);
    check("rst_wgt_full", {127'd0, wgt_full}, 128'd0);
    check("rst_act_rdy",  {127'd0, act_rdy},  128'd0);
    check("rst_psum",     {96'd0, psum},      128'd0);
    check("rst_state",    {126'd0, shadow_state}, {126'd0, EMPTY});
    repeat (4) tick();
    act_vld = 1'b0;

    // All weights 1, window all 2 -> 18 per channel.
    for (int i = 0; i < 4; i++) load_word(32'h0101_0101);
    check("load_state_mid", {126'd0, shadow_state}, {126'd0, LOADING});
    for (int i = 4; i < 9; i++) load_word(32'h0101_0101);
    check("full_flag", {127'd0, wgt_full}, 128'd1);
    check("full_rdy",  {127'd0, wgt_rdy},  128'd0);
    do_swap();
    check("swap_act_rdy", {127'd0, act_rdy},  128'd1);
    check("swap_empty",   {127'd0, wgt_full}, 128'd0);
    send_act({9{8'd2}}, 32'h1212_1212);
    drain();
    check("psum_hold", {96'd0, psum}, {96'd0, 32'h1212_1212});

    // Distinct channels, ramp window i-4: expect ch3..ch0 = 60,12,60,0.
    for (int i = 0; i < 9; i++) load_word(mix_word(i));
    do_swap();
    for (int i = 0; i < 9; i++) ramp[i*8 +: 8] = 8'(i - 4);
    send_act(ramp, {8'd60, 8'd12, 8'd60, 8'd0});
    drain();

    // Positive saturation: 127*127*9 -> 127.
    for (int i = 0; i < 9; i++) load_word(32'h7F7F_7F7F);
    do_swap();
    send_act({9{8'h7F}}, 32'h7F7F_7F7F);
    drain();

    // Negative saturation: -128*127*9 -> -128 (or 0 with ReLU).
    for (int i = 0; i < 9; i++) load_word(32'h8080_8080);
    do_swap();
    send_act({9{8'h7F}}, NEG_SAT);
    drain();

    // Swap during LOADING is ignored and not remembered.
    for (int i = 0; i < 4; i++) load_word(32'h0101_0101);
    do_swap();
    check("swap_ignored_state", {126'd0, shadow_state}, {126'd0, LOADING});
    for (int i = 4; i < 9; i++) load_word(32'h0101_0101);
    // FULL with wgt_vld held: no acceptance, no late swap.
    wgt_vld  = 1'b1;
    wgt_data = 32'h0505_0505;
    repeat (3) begin
      tick();
      check("full_hold_rdy",  {127'd0, wgt_rdy},  128'd0);
      check("full_hold_full", {127'd0, wgt_full}, 128'd1);
    end
    wgt_vld = 1'b0;
    send_act({9{8'h7F}}, NEG_SAT);
    drain();
    do_swap();
    // A single overwritten word of 5 would give 26 instead of 18.
    send_act({9{8'd2}}, 32'h1212_1212);
    drain();

    // Streaming with swap to weights=2 on the third window.
    for (int i = 0; i < 9; i++) load_word(32'h0202_0202);
    for (int j = 0; j < 6; j++) begin
      bank_swap = (j == 2);
      send_act({9{8'd2}}, (j <= 2) ? 32'h1212_1212 : 32'h2424_2424);
    end
    bank_swap = 1'b0;
    drain();

    // Reset with a 5-word partial load and two windows in flight.
    for (int j = 0; j < 5; j++) begin
      wgt_vld  = 1'b1;
      wgt_data = 32'h0404_0404;
      act_vld  = (j >= 3);
      act_data = {9{8'd2}};
      tick();
    end
    wgt_vld = 1'b0;
    act_vld = 1'b0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("mid_rst_act_rdy", {127'd0, act_rdy},  128'd0);
    check("mid_rst_state",   {126'd0, shadow_state}, {126'd0, EMPTY});
    check("mid_rst_full",    {127'd0, wgt_full}, 128'd0);
    check("mid_rst_psum",    {96'd0, psum},      128'd0);
    // Index restarts at 0: eight words are still not a full bank.
    for (int i = 0; i < 8; i++) load_word(32'h0101_0101);
    check("restart_idx_8", {127'd0, wgt_full}, 128'd0);
    load_word(32'h0101_0101);
    check("restart_idx_9", {127'd0, wgt_full}, 128'd1);
    do_swap();
    send_act({9{8'd2}}, 32'h1212_1212);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
